mskg4_unmask_stream: RTL and testbench
======================================

Name: mskg4_unmask_stream

Overview:
- Streaming unmasking endpoint for GF(4) sharings such as those produced by the masked GF(4) DOM multiplier.
- Accepts beats of NSYM bit-sliced d-share GF(4) symbols over valid/ready and registers the shares as a glitch barrier.
- Recombines each symbol's shares with XOR and delivers unshared 2-bit symbols over valid/ready.
- Sits at the boundary where masked datapath results leave the protected domain; gated by an explicit unmask enable.

Parameters:
- d, 2, number of shares per bit (codebase DEFAULTSHARES).
- NSYM, 4, GF(4) symbols per beat.
- CNTW, 16, width of the delivered-beat and dropped-beat counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_sh0  in  NSYM*d  share bits of symbol bit 0; symbol k, share i at index k*d+i.
- in_sh1  in  NSYM*d  share bits of symbol bit 1; same indexing.
- unmask_en  in  1  permits recombination; sampled when a beat leaves stage 1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat consumed when out_valid && out_ready.
- out_data  out  2*NSYM  unshared symbols; symbol k at [2k+1:2k], where bit0 = XOR of shares of in_sh0 and bit1 = XOR of shares of in_sh1.
- beats_out  out  CNTW  count of delivered output beats; wraps modulo 2^CNTW.
- beats_drop  out  CNTW  count of beats discarded because unmask_en was low; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid=0, out_valid=0, out_data=0, beats_out=0, beats_drop=0.
  - Share registers are cleared to 0 so that no stale sharing survives reset.
  - Reset mid-operation discards all in-flight beats; counters are not restored.
- Stage 1 (share register):
  - Loads in_sh0/in_sh1 only on input handshake; holds otherwise. No combinational path from in_sh* to any output.
  - in_ready = !s1_valid || s1_adv, where s1_adv = s1_valid && (!out_valid || out_ready).
- Stage 2 (output register):
  - On s1_adv with unmask_en=1: out_data <= per-symbol XOR of the d registered shares; out_valid <= 1; beats_out increments.
  - On s1_adv with unmask_en=0: beat dropped; out_data unchanged; out_valid <= 0 unless a pending beat is held; beats_drop increments.
  - On handshake at the output with no s1_adv: out_valid <= 0; out_data holds its last value (no combinational zeroing).
- Latency and throughput:
  - Accept at cycle t gives out_valid at t+2 with no backpressure.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Backpressure:
  - out_valid && !out_ready stalls stage 2. Stage 1 holds; in_ready=0 once s1_valid.
  - out_data and out_valid are stable while stalled.
- Simultaneous events:
  - Output handshake together with s1_adv replaces the beat in the same cycle; out_valid stays 1.
  - Input accept together with s1_adv refills stage 1 in the same cycle.
- Counters wrap 2^CNTW-1 -> 0 silently.
- unmask_en changes only affect the beat advancing in that cycle; no partial beats.

Decomposition:
- Package mskg4_pkg holds:
  - DEFAULTSHARES.
  - G4_W=2.
  - An index function sh_idx(k,i)=k*d+i, shared with the masked gadgets.
- Sub-module mskg4_recombine (d-input XOR reduction for one GF(4) symbol, 2 bits), instantiated NSYM times between stage 1 and stage 2.

Test Plan (d=2, NSYM=4):
- Basic recombination:
  - Stimulus: one beat, unmask_en=1, out_ready=1; symbol0 in_sh0[1:0]=2'b11, in_sh1[1:0]=2'b10, other symbols all-zero shares.
  - Response: out_valid at t+2, out_data=8'h02, beats_out=1.
- Streaming:
  - Stimulus: 8 back-to-back beats with out_ready=1.
  - Response: 8 consecutive out_valid cycles starting t+2, in_ready constantly 1, beats_out=8.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during a stream.
  - Response: in_ready=0 after stage 1 fills, out_data stable, no beat lost or duplicated; order preserved when released.
- Drop path:
  - Stimulus: unmask_en=0 for beats 2-3 of 4.
  - Response: only beats 1 and 4 appear on the output, beats_drop=2, beats_out=2.
- Reset mid-stream:
  - Stimulus: rst_n low asynchronously with both stages full.
  - Response: out_valid=0, out_data=0, counters 0 immediately; first post-reset beat appears 2 cycles after accept.
- Counter wrap:
  - Stimulus: CNTW=4, deliver 17 beats.
  - Response: beats_out=1.

Source files
------------

// File: rtl/mskg4_pkg.sv
// Shared constants and share-indexing helper for the masked GF(4) datapath.
// No logic, no latency.
// Imported by gadgets and the unmask stream so share layout stays consistent.
package mskg4_pkg;

    // Default number of shares per bit across the masked GF(4) gadgets.
    localparam int DEFAULTSHARES = 2;

    // Bits per GF(4) symbol.
    localparam int G4_W = 2;

    // Bit position of share i of symbol k in a bit-sliced share vector.
    function automatic int sh_idx(input int k, input int i, input int d);
        return k * d + i;
    endfunction

endpackage

// File: rtl/mskg4_unmask_stream_if.sv
// Valid/ready bundle for the unmask stream: shared beats in, unshared symbols out.
// No logic, no latency.
// The slave modport is the endpoint's view; master is the producer/consumer side.
interface mskg4_unmask_stream_if
    import mskg4_pkg::*;
#(
    parameter int D    = DEFAULTSHARES,
    parameter int NSYM = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NSYM*D-1:0]      in_sh0;
    logic [NSYM*D-1:0]      in_sh1;
    logic                   out_valid;
    logic                   out_ready;
    logic [G4_W*NSYM-1:0]   out_data;

    modport slave (
        input  in_valid, in_sh0, in_sh1, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_sh0, in_sh1, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mskg4_recombine.sv
// XOR-reduces the D shares of one GF(4) symbol back to its 2-bit value.
// Purely combinational, zero latency.
// No handshake; fed only from registered shares so glitches cannot combine shares early.
module mskg4_recombine
    import mskg4_pkg::*;
#(
    parameter int D = DEFAULTSHARES
) (
    input  logic [D-1:0]    sh0,
    input  logic [D-1:0]    sh1,
    output logic [G4_W-1:0] sym
);

    // Each symbol bit is the parity of its shares.
    assign sym = {^sh1, ^sh0};

endmodule

// File: rtl/mskg4_unmask_stream.sv
// Unmasking endpoint: registers d-share GF(4) beats, recombines shares, emits plain symbols.
// Two-cycle latency (share register, then output register); one beat per cycle sustained.
// Output stall holds stage 2, stage 1 fills and then in_ready drops; nothing is lost.
module mskg4_unmask_stream
    import mskg4_pkg::*;
#(
    parameter int D    = DEFAULTSHARES,
    parameter int NSYM = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mskg4_unmask_stream_if.slave bus,
    input  logic                 unmask_en,
    output logic [CNTW-1:0]      beats_out,
    output logic [CNTW-1:0]      beats_drop
);

    logic                   s1_valid;
    logic [NSYM*D-1:0]      sh0_q;
    logic [NSYM*D-1:0]      sh1_q;
    logic                   out_valid_q;
    logic [G4_W*NSYM-1:0]   out_data_q;
    logic [G4_W*NSYM-1:0]   recomb;
    logic                   s1_adv;
    logic                   in_fire;
    logic                   out_fire;

    assign s1_adv      = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign out_fire    = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // One recombiner per symbol, reading only the stage-1 share registers.
    for (genvar k = 0; k < NSYM; k++) begin : g_sym
        mskg4_recombine #(.D(D)) u_recombine (
            .sh0 (sh0_q[sh_idx(k, 0, D) +: D]),
            .sh1 (sh1_q[sh_idx(k, 0, D) +: D]),
            .sym (recomb[G4_W*k +: G4_W])
        );
    end

    // Stage 1: capture shares on input handshake only; cleared on reset so no old sharing lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            sh0_q    <= '0;
            sh1_q    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            sh0_q    <= bus.in_sh0;
            sh1_q    <= bus.in_sh1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: deliver or drop the advancing beat depending on unmask_en; keep data on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beats_out   <= '0;
            beats_drop  <= '0;
        end else if (s1_adv) begin
            if (unmask_en) begin
                out_valid_q <= 1'b1;
                out_data_q  <= recomb;
                beats_out   <= beats_out + 1'b1;
            end else begin
                // s1_adv implies the output slot is empty or being consumed, so nothing is pending.
                out_valid_q <= 1'b0;
                beats_drop  <= beats_drop + 1'b1;
            end
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mskg4_unmask_stream.sv
module tb_mskg4_unmask_stream;
    localparam int D    = 2;
    localparam int NSYM = 4;
    localparam int CNTW = 4;
    localparam int CMOD = 1 << CNTW;

    logic clk = 1'b0;
    logic rst_n;
    logic unmask_en;
    logic [CNTW-1:0] beats_out;
    logic [CNTW-1:0] beats_drop;

    mskg4_unmask_stream_if #(.D(D), .NSYM(NSYM)) bus ();

    mskg4_unmask_stream #(.D(D), .NSYM(NSYM), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .unmask_en  (unmask_en),
        .beats_out  (beats_out),
        .beats_drop (beats_drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected delivered symbols in order, plus expected counter totals.
    logic [7:0] exp_q[$];
    int exp_out_cnt  = 0;
    int exp_drop_cnt = 0;
    int delivered    = 0;
    logic       hold_vld = 1'b0;
    logic [7:0] hold_dat = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] unshare(input logic [7:0] s0, input logic [7:0] s1);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NSYM; k++) begin
            for (int i = 0; i < D; i++) begin
                r[2*k]   = r[2*k]   ^ s0[k*D+i];
                r[2*k+1] = r[2*k+1] ^ s1[k*D+i];
            end
        end
        return r;
    endfunction

    // Monitor: score every output handshake and require stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(hold_dat));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                    delivered++;
                end
            end
            hold_vld = bus.out_valid && !bus.out_ready;
            hold_dat = bus.out_data;
        end
    end

    // Present one beat until accepted; model records it at the accepting edge.
    task automatic send_beat(input logic [7:0] s0, input logic [7:0] s1, output int waited);
        bit got;
        got = 0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_sh0   = s0;
        bus.in_sh1   = s1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                if (unmask_en) begin
                    exp_q.push_back(unshare(s0, s1));
                    exp_out_cnt++;
                end else begin
                    exp_drop_cnt++;
                end
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        bus.in_valid = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_out_cnt  = 0;
        exp_drop_cnt = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_beats_out"},  32'(beats_out),  32'(exp_out_cnt % CMOD));
        check({tag, "_beats_drop"}, 32'(beats_drop), 32'(exp_drop_cnt % CMOD));
    endtask

    initial begin
        int w;
        int d0;
        logic [7:0] r0;
        logic [7:0] r1;
        rst_n         = 1'b0;
        unmask_en     = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sh0    = '0;
        bus.in_sh1    = '0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_beats_out", 32'(beats_out), 32'd0);
        check("rst_beats_drop", 32'(beats_drop), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        do_reset();

        // Basic recombination and latency.
        send_beat(8'b0000_0011, 8'b0000_0010, w);
        @(negedge clk);
        check("basic_lat1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("basic_lat2_valid", 32'(bus.out_valid), 32'd1);
        check("basic_data", 32'(bus.out_data), 32'h02);
        check("basic_beats_out", 32'(beats_out), 32'd1);
        drain();

        // Back-to-back stream with out_ready high: never wait on in_ready.
        d0 = delivered;
        for (int b = 0; b < 8; b++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            send_beat(r0, r1, w);
            check("stream_no_wait", 32'(w), 32'd0);
        end
        drain();
        check("stream_delivered", 32'(delivered - d0), 32'd8);
        check_counters("stream");

        // Backpressure: hold out_ready low for 5 cycles mid-stream.
        d0 = delivered;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    r0 = 8'($urandom);
                    r1 = 8'($urandom);
                    send_beat(r0, r1, w);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 32'(delivered - d0), 32'd6);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check_counters("bp");

        // Drop path: beats 2 and 3 of 4 with unmask_en low.
        do_reset();
        d0 = delivered;
        for (int b = 0; b < 4; b++) begin
            unmask_en = (b == 0 || b == 3);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            send_beat(r0, r1, w);
            repeat (2) @(posedge clk);
            #1;
        end
        unmask_en = 1'b1;
        drain();
        check("drop_delivered", 32'(delivered - d0), 32'd2);
        check("drop_beats_out", 32'(beats_out), 32'd2);
        check("drop_beats_drop", 32'(beats_drop), 32'd2);
        check_counters("drop");

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        send_beat(8'($urandom), 8'($urandom), w);
        send_beat(8'($urandom), 8'($urandom), w);
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_beats_out", 32'(beats_out), 32'd0);
        check("mid_rst_beats_drop", 32'(beats_drop), 32'd0);
        exp_q.delete();
        exp_out_cnt  = 0;
        exp_drop_cnt = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_beat(8'($urandom), 8'($urandom), w);
        @(negedge clk);
        check("post_rst_lat1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_lat2_valid", 32'(bus.out_valid), 32'd1);
        drain();
        check_counters("post_rst");

        // Counter wrap: 17 beats through a 4-bit counter.
        do_reset();
        for (int b = 0; b < 17; b++) begin
            send_beat(8'($urandom), 8'($urandom), w);
        end
        drain();
        check("wrap_beats_out", 32'(beats_out), 32'd1);
        check_counters("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
